// File: rtl/ll_pkg.sv
// Shared types for the logical-link transmit path.
package ll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } ll_tx_sched_state_t;

endpackage : ll_pkg

// File: rtl/ll_rr_arb.sv
// Combinational round-robin find-first: searches req from ptr+1 upward, wrapping.
module ll_rr_arb #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid
);

    always_comb begin : p_find
        int unsigned      sum;
        logic [PTR_W-1:0] idx;
        sum       = 0;
        idx       = '0;
        gnt       = '0;
        gnt_valid = 1'b0;
        // Offset N wraps back onto ptr itself, so the last holder is considered last.
        for (int k = 1; k <= N; k++) begin
            sum = int'(ptr) + k;
            idx = PTR_W'(sum % N);
            if (!gnt_valid && req[idx]) begin
                gnt[idx]  = 1'b1;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule : ll_rr_arb

// File: rtl/ll_tx_sched.sv
// Credit-based round-robin scheduler sharing one link slot among NUM_CH TX FIFOs.
module ll_tx_sched
    import ll_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CRED_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic              clk_wr,
    input  logic              rst_wr_n,
    input  logic              tx_online,
    input  logic [CRED_W-1:0] init_credit,
    input  logic [NUM_CH-1:0] txfifo_empty,
    input  logic [NUM_CH-1:0] rx_credit_ret,
    output logic [NUM_CH-1:0] txfifo_pop,
    output logic              tx_valid,
    output logic [SEL_W-1:0]  tx_sel,
    output logic              credit_err
);

    localparam logic [CRED_W-1:0] CRED_MAX = {CRED_W{1'b1}};
    localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);
    localparam logic [SEL_W-1:0]  PTR_RST  = SEL_W'(NUM_CH - 1);

    ll_tx_sched_state_t state_reg, state_next;
    logic [SEL_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic               tx_valid_reg;
    logic [SEL_W-1:0]   tx_sel_reg;
    logic               credit_err_reg;

    logic [NUM_CH-1:0]  eligible;
    logic [NUM_CH-1:0]  grant;
    logic [NUM_CH-1:0]  overflow;
    logic               grant_valid;
    logic               pop_en;
    logic [SEL_W-1:0]   grant_idx;

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= PTR_RST;
            tx_valid_reg   <= 1'b0;
            tx_sel_reg     <= '0;
            credit_err_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            tx_valid_reg   <= pop_en && grant_valid;
            if (pop_en && grant_valid) begin
                tx_sel_reg <= grant_idx;
            end
            credit_err_reg <= credit_err_reg | (|overflow);
        end
    end

    // Pops are only allowed in RUN while the link stays up this very cycle.
    always_comb begin
        state_next = state_reg;
        pop_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (tx_online) state_next = LOAD;
            end
            LOAD: begin
                state_next = tx_online ? RUN : IDLE;
            end
            RUN: begin
                if (tx_online) pop_en = 1'b1;
                else           state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    ll_rr_arb #(
        .N     (NUM_CH),
        .PTR_W (SEL_W)
    ) u_arb (
        .req       (eligible),
        .ptr       (rr_ptr_reg),
        .gnt       (grant),
        .gnt_valid (grant_valid)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) grant_idx = SEL_W'(i);
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (state_reg == RUN && !tx_online) begin
            rr_ptr_next = PTR_RST;
        end else if (pop_en && grant_valid) begin
            rr_ptr_next = grant_idx;
        end
    end

    assign txfifo_pop = pop_en ? grant : '0;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cred
        logic [CRED_W-1:0] cred_reg, cred_next;
        logic              ovf;

        // Anything other than LOAD/RUN with the link up clears the counter.
        always_comb begin
            cred_next = '0;
            ovf       = 1'b0;
            case (state_reg)
                LOAD: begin
                    if (tx_online) begin
                        if (rx_credit_ret[gi] && init_credit == CRED_MAX)
                            cred_next = CRED_MAX;
                        else
                            cred_next = init_credit + CRED_W'(rx_credit_ret[gi]);
                    end
                end
                RUN: begin
                    if (tx_online) begin
                        cred_next = cred_reg;
                        if (txfifo_pop[gi] && !rx_credit_ret[gi]) begin
                            cred_next = cred_reg - CRED_ONE;
                        end else if (!txfifo_pop[gi] && rx_credit_ret[gi]) begin
                            if (cred_reg == CRED_MAX) ovf = 1'b1;
                            else                      cred_next = cred_reg + CRED_ONE;
                        end
                    end
                end
                default: cred_next = '0;
            endcase
        end

        always_ff @(posedge clk_wr or negedge rst_wr_n) begin
            if (!rst_wr_n) cred_reg <= '0;
            else           cred_reg <= cred_next;
        end

        assign eligible[gi] = ~txfifo_empty[gi] && (cred_reg != '0);
        assign overflow[gi] = ovf;
    end

    assign tx_valid   = tx_valid_reg;
    assign tx_sel     = tx_sel_reg;
    assign credit_err = credit_err_reg;

endmodule : ll_tx_sched

// File: tb/tb_ll_tx_sched.sv
// Scoreboard bench for ll_tx_sched: expected pop order queued at stimulus time.
`timescale 1ns/1ps
module tb_ll_tx_sched;

    logic       clk_wr   = 1'b0;
    logic       rst_wr_n = 1'b0;

    // Main instance: 4 channels, 8-bit credits
    logic       tx_online;
    logic [7:0] init_credit;
    logic [3:0] txfifo_empty;
    logic [3:0] rx_credit_ret;
    logic [3:0] txfifo_pop;
    logic       tx_valid;
    logic [1:0] tx_sel;
    logic       credit_err;

    // Small instance: 2-bit credits for the overflow case
    logic       s_online;
    logic [1:0] s_init;
    logic [3:0] s_empty;
    logic [3:0] s_ret;
    logic [3:0] s_pop;
    logic       s_valid;
    logic [1:0] s_sel;
    logic       s_err;

    int         errors = 0;
    int         checks = 0;
    int         exp_q[$];
    logic [3:0] last_pop;
    int         s_pops;

    always #5 clk_wr = ~clk_wr;

    ll_tx_sched #(.NUM_CH(4), .CRED_W(8)) u_dut (
        .clk_wr        (clk_wr),
        .rst_wr_n      (rst_wr_n),
        .tx_online     (tx_online),
        .init_credit   (init_credit),
        .txfifo_empty  (txfifo_empty),
        .rx_credit_ret (rx_credit_ret),
        .txfifo_pop    (txfifo_pop),
        .tx_valid      (tx_valid),
        .tx_sel        (tx_sel),
        .credit_err    (credit_err)
    );

    ll_tx_sched #(.NUM_CH(4), .CRED_W(2)) u_dut_small (
        .clk_wr        (clk_wr),
        .rst_wr_n      (rst_wr_n),
        .tx_online     (s_online),
        .init_credit   (s_init),
        .txfifo_empty  (s_empty),
        .rx_credit_ret (s_ret),
        .txfifo_pop    (s_pop),
        .tx_valid      (s_valid),
        .tx_sel        (s_sel),
        .credit_err    (s_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        int   exp_ch;
        logic exp_v;
        exp_ch = 0;
        exp_v  = 1'b0;
        #1;
        last_pop = txfifo_pop;
        if (s_pop != 4'b0000) s_pops++;
        if (txfifo_pop != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pop", 32'(txfifo_pop), 32'd0);
            end else begin
                exp_ch = exp_q.pop_front();
                exp_v  = 1'b1;
                check("pop_ch", 32'(txfifo_pop), 32'd1 << exp_ch);
                $display("pop: vec=%b expected ch%0d @%0t", txfifo_pop, exp_ch, $time);
            end
        end
        @(posedge clk_wr);
        #1;
        check("tx_valid", 32'(tx_valid), 32'(exp_v));
        if (exp_v) check("tx_sel", 32'(tx_sel), 32'(exp_ch));
        @(negedge clk_wr);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic push_rr(input int first, input int count);
        for (int i = 0; i < count; i++) exp_q.push_back((first + i) % 4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_online     = 1'b0;
        init_credit   = 8'd3;
        txfifo_empty  = 4'b0000;
        rx_credit_ret = 4'b0000;
        s_online      = 1'b0;
        s_init        = 2'd3;
        s_empty       = 4'b1111;
        s_ret         = 4'b0000;
        s_pops        = 0;
        last_pop      = 4'b0000;

        // Reset values
        #1;
        check("rst_pop", 32'(txfifo_pop), 32'd0);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_sel", 32'(tx_sel), 32'd0);
        check("rst_err", 32'(credit_err), 32'd0);
        repeat (2) @(negedge clk_wr);
        rst_wr_n = 1'b1;
        s_online = 1'b1;
        run(8);

        // Bring-up: IDLE and LOAD cycles pop nothing, then 3 rounds of ch0..ch3
        tx_online = 1'b1;
        cycle();
        check("bringup_idle_pop", 32'(last_pop), 32'd0);
        cycle();
        check("bringup_load_pop", 32'(last_pop), 32'd0);
        push_rr(0, 12);
        run(16);
        check("bringup_drain", 32'(exp_q.size()), 32'd0);

        // Credit return on ch2: not usable in the return cycle, usable next
        rx_credit_ret = 4'b0100;
        cycle();
        check("ret_same_cycle_pop", 32'(last_pop), 32'd0);
        rx_credit_ret = 4'b0000;
        exp_q.push_back(2);
        run(4);
        check("ret_drain", 32'(exp_q.size()), 32'd0);

        // ch1 at one credit, pop and return together keep it at one
        rx_credit_ret = 4'b0010;
        cycle();
        check("simul_prep_pop", 32'(last_pop), 32'd0);
        exp_q.push_back(1);
        exp_q.push_back(1);
        cycle();
        rx_credit_ret = 4'b0000;
        run(4);
        check("simul_drain", 32'(exp_q.size()), 32'd0);

        // Fairness: ch0/ch3 loaded with 3 credits each, ch1/ch2 empty
        txfifo_empty  = 4'b1111;
        rx_credit_ret = 4'b1001;
        run(3);
        rx_credit_ret = 4'b0000;
        txfifo_empty  = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(3);
            exp_q.push_back(0);
        end
        run(9);
        check("fair_drain", 32'(exp_q.size()), 32'd0);

        // Offline mid-stream, then re-online with new init_credit
        txfifo_empty = 4'b0000;
        tx_online    = 1'b0;
        cycle();
        tx_online    = 1'b1;
        run(2);
        push_rr(0, 5);
        run(5);
        tx_online = 1'b0;
        cycle();
        check("offline_drop_pop", 32'(last_pop), 32'd0);
        cycle();
        init_credit = 8'd2;
        tx_online   = 1'b1;
        cycle();
        check("reonline_idle_pop", 32'(last_pop), 32'd0);
        cycle();
        check("reonline_load_pop", 32'(last_pop), 32'd0);
        push_rr(0, 8);
        run(10);
        check("reonline_drain", 32'(exp_q.size()), 32'd0);

        // Overflow on 2-bit counters already holding 3
        check("ovf_err_before", 32'(s_err), 32'd0);
        s_ret = 4'b0001;
        check("ovf_err_same_cycle", 32'(s_err), 32'd0);
        cycle();
        s_ret = 4'b0000;
        check("ovf_err_set", 32'(s_err), 32'd1);
        s_pops  = 0;
        s_empty = 4'b1110;
        run(6);
        check("ovf_ch0_pops", 32'(s_pops), 32'd3);
        check("ovf_err_sticky", 32'(s_err), 32'd1);

        // Reset mid-stream
        txfifo_empty  = 4'b1111;
        rx_credit_ret = 4'b1111;
        run(3);
        rx_credit_ret = 4'b0000;
        txfifo_empty  = 4'b0000;
        push_rr(0, 3);
        run(3);
        check("prereset_drain", 32'(exp_q.size()), 32'd0);
        #1;
        check("prereset_pop", 32'(txfifo_pop), 32'b1000);
        rst_wr_n = 1'b0;
        #1;
        check("midrst_pop", 32'(txfifo_pop), 32'd0);
        check("midrst_valid", 32'(tx_valid), 32'd0);
        check("midrst_sel", 32'(tx_sel), 32'd0);
        check("midrst_err", 32'(s_err), 32'd0);
        check("midrst_s_pop", 32'(s_pop), 32'd0);
        @(posedge clk_wr);
        #1;
        check("inrst_pop", 32'(txfifo_pop), 32'd0);
        check("inrst_valid", 32'(tx_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ll_tx_sched
